// File: rtl/alu_op_server.sv
// Responder for the shared-ALU micro-op interface: round-robin arbitration between two
// clients, one-cycle ALU issue, registered result returned over a valid/ready handshake.
module alu_op_server #(
    parameter int W     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cpu_busy_i,
    input  logic [1:0]       req_valid_i,
    output logic [1:0]       req_ready_o,
    input  logic [2:0]       req_oper0_i,
    input  logic [2:0]       req_oper1_i,
    input  logic [W-1:0]     req_a0_i,
    input  logic [W-1:0]     req_a1_i,
    input  logic [W-1:0]     req_b0_i,
    input  logic [W-1:0]     req_b1_i,
    output logic             alu_sel_o,
    output logic [2:0]       alu_oper_o,
    output logic [W-1:0]     alu_a_o,
    output logic [W-1:0]     alu_b_o,
    input  logic [W-1:0]     alu_result_i,
    input  logic             alu_zero_i,
    output logic [1:0]       rsp_valid_o,
    input  logic [1:0]       rsp_ready_i,
    output logic [W-1:0]     rsp_data_o,
    output logic             rsp_zero_o,
    output logic [CNT_W-1:0] ops_done_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t state, state_next;
    logic   last_grant;
    logic   grant;
    logic   grant_valid;
    logic   rsp_done;

    // NOTE: every signal assigned in this block gets a default first, so no path leaves a latch.
    always_comb begin
        state_next  = state;
        grant       = 1'b0;
        grant_valid = 1'b0;
        rsp_done    = 1'b0;
        req_ready_o = 2'b00;
        alu_sel_o   = 1'b0;
        rsp_valid_o = 2'b00;
        unique case (state)
            IDLE: begin
                // Nothing is accepted during a reset cycle, so a client never sees a phantom grant.
                if (!cpu_busy_i && !rst_i && req_valid_i != 2'b00) begin
                    grant_valid = 1'b1;
                    unique case (req_valid_i)
                        2'b01:   grant = 1'b0;
                        2'b10:   grant = 1'b1;
                        default: grant = ~last_grant;
                    endcase
                    req_ready_o = grant ? 2'b10 : 2'b01;
                    state_next  = ISSUE;
                end
            end
            ISSUE: begin
                alu_sel_o  = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                rsp_valid_o = last_grant ? 2'b10 : 2'b01;
                rsp_done    = rsp_ready_i[last_grant];
                if (rsp_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            alu_oper_o <= '0;
            alu_a_o    <= '0;
            alu_b_o    <= '0;
            rsp_data_o <= '0;
            rsp_zero_o <= 1'b0;
            ops_done_o <= '0;
        end else begin
            state <= state_next;
            // The ALU operand registers double as the request latch and hold between operations.
            if (grant_valid) begin
                last_grant <= grant;
                alu_oper_o <= grant ? req_oper1_i : req_oper0_i;
                alu_a_o    <= grant ? req_a1_i    : req_a0_i;
                alu_b_o    <= grant ? req_b1_i    : req_b0_i;
            end
            if (state == ISSUE) begin
                rsp_data_o <= alu_result_i;
                rsp_zero_o <= alu_zero_i;
            end
            if (rsp_done) begin
                ops_done_o <= ops_done_o + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_op_server.sv
// Directed bench for alu_op_server: a small ALU model closes the loop, and each scenario
// task compares outputs against hand-computed values.
module tb_alu_op_server;

    localparam int W     = 32;
    localparam int CNT_W = 4;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_SRL  = 3'b010;
    localparam logic [2:0] ALU_SLTU = 3'b011;
    localparam logic [2:0] ALU_SUB  = 3'b100;
    localparam logic [2:0] ALU_SLL  = 3'b101;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cpu_busy = 1'b0;
    logic [1:0]       req_valid = 2'b00;
    logic [1:0]       req_ready;
    logic [2:0]       req_oper0 = 3'd0, req_oper1 = 3'd0;
    logic [W-1:0]     req_a0 = '0, req_a1 = '0, req_b0 = '0, req_b1 = '0;
    logic             alu_sel;
    logic [2:0]       alu_oper;
    logic [W-1:0]     alu_a, alu_b;
    logic [W-1:0]     alu_result;
    logic             alu_zero;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready = 2'b11;
    logic [W-1:0]     rsp_data;
    logic             rsp_zero;
    logic [CNT_W-1:0] ops_done;

    int               vectors = 0;
    int               miscompares = 0;
    logic [CNT_W-1:0] exp_done = '0;

    always #5 clk = ~clk;

    alu_op_server #(.W(W), .CNT_W(CNT_W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cpu_busy_i  (cpu_busy),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_oper0_i (req_oper0),
        .req_oper1_i (req_oper1),
        .req_a0_i    (req_a0),
        .req_a1_i    (req_a1),
        .req_b0_i    (req_b0),
        .req_b1_i    (req_b1),
        .alu_sel_o   (alu_sel),
        .alu_oper_o  (alu_oper),
        .alu_a_o     (alu_a),
        .alu_b_o     (alu_b),
        .alu_result_i(alu_result),
        .alu_zero_i  (alu_zero),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_data_o  (rsp_data),
        .rsp_zero_o  (rsp_zero),
        .ops_done_o  (ops_done)
    );

    // Stand-in for sr_alu, always fed from this block's mux outputs.
    always_comb begin
        case (alu_oper)
            ALU_ADD:  alu_result = alu_a + alu_b;
            ALU_OR:   alu_result = alu_a | alu_b;
            ALU_SRL:  alu_result = alu_a >> alu_b[4:0];
            ALU_SLTU: alu_result = (alu_a < alu_b) ? 32'd1 : 32'd0;
            ALU_SUB:  alu_result = alu_a - alu_b;
            ALU_SLL:  alu_result = alu_a << alu_b[4:0];
            default:  alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
    end

    // Lands 1 time unit after the rising edge: registered outputs are settled, inputs are driven here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int c, input logic [2:0] oper, input logic [W-1:0] a,
                           input logic [W-1:0] b);
        if (c == 0) begin
            req_oper0 = oper; req_a0 = a; req_b0 = b;
        end else begin
            req_oper1 = oper; req_a1 = a; req_b1 = b;
        end
        req_valid[c] = 1'b1;
    endtask

    // One full transaction from an IDLE cycle with requests already driven; zero-wait responder.
    task automatic run_op(input int c, input logic [W-1:0] exp_data, input logic exp_zero,
                          input string name);
        logic [1:0] oh;
        oh = (c == 0) ? 2'b01 : 2'b10;
        #1;
        vectors++;
        if (req_ready !== oh) begin
            miscompares++;
            $display("FAIL %s req_ready: got %b expected %b", name, req_ready, oh);
        end
        step();
        req_valid[c] = 1'b0;
        #1;
        vectors++;
        if (alu_sel !== 1'b1 || req_ready !== 2'b00) begin
            miscompares++;
            $display("FAIL %s issue: alu_sel=%b req_ready=%b expected 1/00", name, alu_sel, req_ready);
        end
        step();
        vectors++;
        if (rsp_valid !== oh || rsp_data !== exp_data || rsp_zero !== exp_zero || alu_sel !== 1'b0) begin
            miscompares++;
            $display("FAIL %s resp: valid=%b data=%0d zero=%b sel=%b expected %b/%0d/%b/0",
                     name, rsp_valid, rsp_data, rsp_zero, alu_sel, oh, exp_data, exp_zero);
        end
        step();
        exp_done++;
        vectors++;
        if (ops_done !== exp_done || rsp_valid !== 2'b00) begin
            miscompares++;
            $display("FAIL %s done: ops_done=%0d rsp_valid=%b expected %0d/00",
                     name, ops_done, rsp_valid, exp_done);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        req_valid = 2'b00;
        cpu_busy = 1'b0;
        rsp_ready = 2'b11;
        step();
        step();
        rst = 1'b0;
        exp_done = '0;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        vectors++;
        if (req_ready !== 2'b00 || alu_sel !== 1'b0 || alu_oper !== 3'd0 || alu_a !== '0 ||
            alu_b !== '0 || rsp_valid !== 2'b00 || rsp_data !== '0 || rsp_zero !== 1'b0 ||
            ops_done !== '0) begin
            miscompares++;
            $display("FAIL reset: ready=%b sel=%b oper=%0d a=%0d b=%0d valid=%b data=%0d zero=%b done=%0d expected all 0",
                     req_ready, alu_sel, alu_oper, alu_a, alu_b, rsp_valid, rsp_data, rsp_zero, ops_done);
        end
        step();
    endtask

    task automatic test_single();
        set_req(0, ALU_ADD, 32'd5, 32'd7);
        #1;
        vectors++;
        if (req_ready !== 2'b01) begin
            miscompares++;
            $display("FAIL single req_ready: got %b expected 01", req_ready);
        end
        step();
        req_valid = 2'b00;
        #1;
        vectors++;
        if (alu_sel !== 1'b1 || alu_oper !== ALU_ADD || alu_a !== 32'd5 || alu_b !== 32'd7) begin
            miscompares++;
            $display("FAIL single issue: sel=%b oper=%0d a=%0d b=%0d expected 1/0/5/7",
                     alu_sel, alu_oper, alu_a, alu_b);
        end
        step();
        vectors++;
        if (rsp_valid !== 2'b01 || rsp_data !== 32'd12 || rsp_zero !== 1'b0 || ops_done !== 4'd0) begin
            miscompares++;
            $display("FAIL single resp: valid=%b data=%0d zero=%b done=%0d expected 01/12/0/0",
                     rsp_valid, rsp_data, rsp_zero, ops_done);
        end
        step();
        exp_done++;
        vectors++;
        if (ops_done !== 4'd1 || alu_sel !== 1'b0 || alu_a !== 32'd5 || alu_b !== 32'd7) begin
            miscompares++;
            $display("FAIL single after: done=%0d sel=%b a=%0d b=%0d expected 1/0/5/7",
                     ops_done, alu_sel, alu_a, alu_b);
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        set_req(0, ALU_SUB, 32'd9, 32'd9);
        set_req(1, ALU_SLL, 32'd1, 32'd4);
        run_op(0, 32'd0, 1'b1, "rr_c0_sub");
        run_op(1, 32'd16, 1'b0, "rr_c1_sll");
        set_req(0, ALU_ADD, 32'd1, 32'd2);
        set_req(1, ALU_OR, 32'd8, 32'd1);
        run_op(0, 32'd3, 1'b0, "rr_pair2_c0");
        run_op(1, 32'd9, 1'b0, "rr_pair2_c1");
    endtask

    task automatic test_cpu_busy();
        cpu_busy = 1'b1;
        set_req(1, ALU_SLTU, 32'd3, 32'd7);
        for (int i = 0; i < 5; i++) begin
            #1;
            vectors++;
            if (req_ready !== 2'b00 || alu_sel !== 1'b0) begin
                miscompares++;
                $display("FAIL busy cycle %0d: req_ready=%b alu_sel=%b expected 00/0", i, req_ready, alu_sel);
            end
            step();
        end
        cpu_busy = 1'b0;
        run_op(1, 32'd1, 1'b0, "busy_release_c1");
    endtask

    task automatic test_backpressure();
        rsp_ready = 2'b00;
        set_req(0, ALU_ADD, 32'd100, 32'd23);
        #1;
        vectors++;
        if (req_ready !== 2'b01) begin
            miscompares++;
            $display("FAIL bp req_ready: got %b expected 01", req_ready);
        end
        step();
        req_valid = 2'b00;
        set_req(1, ALU_SRL, 32'd64, 32'd2);
        step();
        // Only the other client's ready is raised; it must not complete client 0's response.
        rsp_ready = 2'b10;
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++;
            if (rsp_valid !== 2'b01 || rsp_data !== 32'd123 || req_ready !== 2'b00 ||
                alu_sel !== 1'b0 || ops_done !== exp_done) begin
                miscompares++;
                $display("FAIL bp stall %0d: valid=%b data=%0d ready=%b sel=%b done=%0d expected 01/123/00/0/%0d",
                         i, rsp_valid, rsp_data, req_ready, alu_sel, ops_done, exp_done);
            end
            step();
        end
        rsp_ready = 2'b01;
        step();
        rsp_ready = 2'b11;
        exp_done++;
        vectors++;
        if (ops_done !== exp_done || rsp_valid !== 2'b00) begin
            miscompares++;
            $display("FAIL bp release: done=%0d valid=%b expected %0d/00", ops_done, rsp_valid, exp_done);
        end
        run_op(1, 32'd16, 1'b0, "bp_pending_c1");
    endtask

    task automatic test_reset_in_issue();
        set_req(0, ALU_ADD, 32'd1, 32'd1);
        step();
        req_valid = 2'b00;
        rst = 1'b1;
        #1;
        vectors++;
        if (alu_sel !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_issue pre: alu_sel=%b expected 1", alu_sel);
        end
        step();
        rst = 1'b0;
        exp_done = '0;
        vectors++;
        if (req_ready !== 2'b00 || alu_sel !== 1'b0 || alu_oper !== 3'd0 || alu_a !== '0 ||
            alu_b !== '0 || rsp_valid !== 2'b00 || rsp_data !== '0 || rsp_zero !== 1'b0 ||
            ops_done !== '0) begin
            miscompares++;
            $display("FAIL rst_issue post: ready=%b sel=%b oper=%0d a=%0d b=%0d valid=%b data=%0d zero=%b done=%0d expected all 0",
                     req_ready, alu_sel, alu_oper, alu_a, alu_b, rsp_valid, rsp_data, rsp_zero, ops_done);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (rsp_valid !== 2'b00) begin
                miscompares++;
                $display("FAIL rst_issue no response %0d: rsp_valid=%b expected 00", i, rsp_valid);
            end
        end
        set_req(0, ALU_ADD, 32'd2, 32'd2);
        set_req(1, ALU_ADD, 32'd3, 32'd3);
        run_op(0, 32'd4, 1'b0, "rst_issue_c0_first");
        run_op(1, 32'd6, 1'b0, "rst_issue_c1_next");
    endtask

    task automatic test_wrap();
        logic [CNT_W-1:0] start;
        start = exp_done;
        for (int i = 1; i <= 16; i++) begin
            set_req(0, ALU_ADD, W'(i), W'(i));
            run_op(0, W'(2 * i), 1'b0, $sformatf("wrap_op%0d", i));
        end
        vectors++;
        if (ops_done !== start) begin
            miscompares++;
            $display("FAIL wrap: ops_done=%0d expected %0d after 16 ops", ops_done, start);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_cpu_busy();
        test_backpressure();
        test_reset_in_issue();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_op_server.md
Name: alu_op_server

Overview:
- Responder side of the shared-ALU micro-op interface. Multi-cycle functional units (sqrt, cub) use this interface to borrow the CPU's single sr_alu.
- Accepts operation requests from two client ports. Arbitrates between them round-robin.
- Drives the ALU input mux for exactly one cycle per granted request, registers the ALU result, and returns it to the requester over a valid/ready response handshake.
- Instantiated beside sr_alu in sr_cpu. Its alu_sel_o output replaces the funcFlag-based selection of the ALU operands.

Parameters:
- W, 32, operand and result width.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- cpu_busy_i  in  1  CPU datapath needs the ALU this cycle; blocks new grants
- req_valid_i  in  2  per-client request valid (bit n = client n)
- req_ready_o  out  2  per-client request accept; one-hot or zero
- req_oper0_i, req_oper1_i  in  3 each  ALU operation code (ALU_* encoding from sr_cpu.vh)
- req_a0_i, req_a1_i  in  W each  operand A
- req_b0_i, req_b1_i  in  W each  operand B
- alu_sel_o  out  1  1 = ALU inputs come from this block
- alu_oper_o  out  3  operation driven to the ALU
- alu_a_o, alu_b_o  out  W each  operands driven to the ALU
- alu_result_i  in  W  ALU result (combinational, same cycle)
- alu_zero_i  in  1  ALU zero flag
- rsp_valid_o  out  2  per-client response valid; one-hot or zero
- rsp_ready_i  in  2  per-client response accept
- rsp_data_o  out  W  registered result
- rsp_zero_o  out  1  registered zero flag
- ops_done_o  out  CNT_W  count of completed responses

Behaviour:
- Reset (rst_i high at a clock edge), synchronous: state=IDLE, last_grant=1, and all outputs cleared: req_ready_o=0, alu_sel_o=0, alu_oper_o/alu_a_o/alu_b_o=0, rsp_valid_o=0, rsp_data_o=0, rsp_zero_o=0, ops_done_o=0. Reset in any state discards an in-flight operation; no response is issued for it.
- FSM state IDLE:
  - grant = chosen client if cpu_busy_i=0 and req_valid_i!=0, else none.
  - Round-robin choice: if only one client is valid, grant that client. If both are valid, grant the client not equal to last_grant.
  - req_ready_o[grant]=1 combinationally in that same cycle.
  - On the accepting edge: latch oper/a/b of the granted client, set last_grant=grant, go to ISSUE.
- FSM state ISSUE (exactly 1 cycle):
  - alu_sel_o=1; alu_oper_o/alu_a_o/alu_b_o driven from the latched registers.
  - At the edge: rsp_data_o<=alu_result_i, rsp_zero_o<=alu_zero_i, go to RESP.
  - cpu_busy_i is ignored in this state; the CPU is stalled through pcEnable while a functional op is active.
- FSM state RESP:
  - rsp_valid_o[last_grant]=1.
  - When rsp_ready_i[last_grant]=1: ops_done_o increments (wraps at 2^CNT_W-1 → 0) and the FSM goes to IDLE.
  - rsp_data_o and rsp_zero_o hold stable until the handshake.
  - rsp_ready_i of the non-granted client is ignored.
- Latency: request accepted at edge N → ALU driven during cycle N+1 → rsp_valid_o high from cycle N+2. Back-to-back throughput: one operation per 3 cycles with zero-wait responders.
- The IDLE → ISSUE transition never occurs while cpu_busy_i=1. A request held under cpu_busy_i=1 stays pending (req_ready_o=0) and is granted in the first cycle cpu_busy_i falls.
- Clients must hold req_* stable while req_valid is high and not accepted. Dropping req_valid before acceptance is legal; no grant results.
- alu_sel_o=0 in IDLE and RESP; alu_oper_o/alu_a_o/alu_b_o then hold their last values (no toggling).
- Width rule: W-bit results are passed through unmodified. Clients truncate to their own width (e.g. [15:0] partial result).

Test Plan:
- Client 0 only, oper=ALU_ADD, a=5, b=7 → req_ready_o=01 in the request cycle; alu_sel_o=1 one cycle later with a=5, b=7; rsp_valid_o=01 and rsp_data_o=12, rsp_zero_o=0 two cycles after acceptance; ops_done_o=1 after the handshake.
- Both clients valid from reset: c0 ALU_SUB 9-9, c1 ALU_SLL 1<<4 → c0 served first with rsp_data=0, rsp_zero=1; then c1 with rsp_data=16. A third simultaneous pair is granted to c0 again (alternation holds).
- cpu_busy_i=1 for 5 cycles with c1 valid → req_ready_o=00 and alu_sel_o=0 throughout; grant to c1 occurs in the cycle cpu_busy_i falls.
- Response backpressure: hold rsp_ready_i=00 for 4 cycles after rsp_valid → rsp_valid_o and rsp_data_o stay stable, no new grant occurs, ops_done_o does not increment until ready.
- rst_i asserted during ISSUE → next cycle all outputs are 0, no response is issued, and the next request is granted to client 0.
- Preload ops_done_o near wrap (run 2^CNT_W completions, or CNT_W=4 with 16 ops) → counter returns to 0 on the wrapping handshake.
